// File: rtl/halt_sched_if.sv
// rtl/halt_sched_if.sv - requester/counter signal bundle for the debug-halt scheduler
interface halt_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int STEP_W  = 8
);
    logic               dbg_mode;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] step_req;
    logic [STEP_W-1:0]  step_len;
    logic               halt_en;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] halt_ack;
    logic               step_done;
    logic               busy;

    modport master (
        output dbg_mode, req, step_req, step_len,
        input  halt_en, grant, halt_ack, step_done, busy
    );

    modport slave (
        input  dbg_mode, req, step_req, step_len,
        output halt_en, grant, halt_ack, step_done, busy
    );
endinterface

// File: rtl/halt_sched.sv
// rtl/halt_sched.sv - round-robin debug-halt scheduler with drain delay and single-step
module halt_sched #(
    parameter int NUM_REQ   = 2,
    parameter int DRAIN_CYC = 2,
    parameter int STEP_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    halt_sched_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, DRAIN, HALTED, STEP} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [3:0]         drain_q, drain_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic               step_flag_q, step_flag_d;
    logic               halt_en_q, halt_en_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               step_done_q, step_done_d;

    logic owner_req;
    logic owner_step;
    int   win;
    int   nxt;

    // Closest set bit at or above start, wrapping; lowest rotated distance wins.
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int start);
        int best_d;
        int d;
        pick   = 0;
        best_d = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            d = j - start;
            if (d < 0) d = d + NUM_REQ;
            if (r[j] && d < best_d) begin
                best_d = d;
                pick   = j;
            end
        end
    endfunction

    assign owner_req  = |(bus.req & grant_q);
    assign owner_step = |(bus.step_req & grant_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            drain_q     <= '0;
            step_cnt_q  <= '0;
            step_flag_q <= 1'b0;
            halt_en_q   <= 1'b0;
            grant_q     <= '0;
            ack_q       <= '0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            drain_q     <= drain_d;
            step_cnt_q  <= step_cnt_d;
            step_flag_q <= step_flag_d;
            halt_en_q   <= halt_en_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            step_done_q <= step_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        drain_d     = drain_q;
        step_cnt_d  = step_cnt_q;
        step_flag_d = step_flag_q;
        halt_en_d   = halt_en_q;
        grant_d     = grant_q;
        ack_d       = ack_q;
        step_done_d = 1'b0;
        win         = pick(bus.req, int'(ptr_q));
        nxt         = (win + 1 == NUM_REQ) ? 0 : win + 1;

        if (state_q == IDLE) begin
            if (bus.dbg_mode && (bus.req != '0)) begin
                grant_d   = NUM_REQ'(1) << win;
                ptr_d     = PTR_W'(nxt);
                halt_en_d = 1'b1;
                drain_d   = 4'(DRAIN_CYC - 1);
                state_d   = DRAIN;
            end
        end else if (!bus.dbg_mode || !owner_req) begin
            // Abort (and plain release from HALTED) dominates every other transition.
            state_d     = IDLE;
            halt_en_d   = 1'b0;
            grant_d     = '0;
            ack_d       = '0;
            step_flag_d = 1'b0;
        end else begin
            case (state_q)
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_d     = HALTED;
                        ack_d       = grant_q;
                        step_done_d = step_flag_q;
                        step_flag_d = 1'b0;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
                HALTED: begin
                    if (owner_step && (bus.step_len != '0)) begin
                        state_d     = STEP;
                        halt_en_d   = 1'b0;
                        ack_d       = '0;
                        step_cnt_d  = bus.step_len - STEP_W'(1);
                        step_flag_d = 1'b1;
                    end
                end
                STEP: begin
                    if (step_cnt_q == '0) begin
                        state_d   = DRAIN;
                        halt_en_d = 1'b1;
                        drain_d   = 4'(DRAIN_CYC - 1);
                    end else begin
                        step_cnt_d = step_cnt_q - STEP_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.halt_en   = halt_en_q;
        bus.grant     = grant_q;
        bus.halt_ack  = ack_q;
        bus.step_done = step_done_q;
        bus.busy      = (state_q != IDLE);
    end
endmodule

// File: tb/tb_halt_sched.sv
// tb/tb_halt_sched.sv - directed scoreboard bench for halt_sched
module tb_halt_sched;
    localparam int NUM_REQ   = 2;
    localparam int DRAIN_CYC = 2;
    localparam int STEP_W    = 8;

    logic clk = 1'b0;
    logic rst_n;

    halt_sched_if #(.NUM_REQ(NUM_REQ), .STEP_W(STEP_W)) bus ();

    halt_sched #(.NUM_REQ(NUM_REQ), .DRAIN_CYC(DRAIN_CYC), .STEP_W(STEP_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    // Push the expected post-edge outputs, advance one edge, then pop and compare.
    task automatic cyc(input string tag, input logic he, input logic [1:0] gr,
                       input logic [1:0] ack, input logic sd, input logic bz);
        exp_t       e;
        exp_t       x;
        logic [6:0] got;
        e.tag = tag;
        e.val = {he, gr, ack, sd, bz};
        sb.push_back(e);
        @(posedge clk);
        #1;
        x   = sb.pop_front();
        got = {bus.halt_en, bus.grant, bus.halt_ack, bus.step_done, bus.busy};
        total++;
        assert (got === x.val) passed++;
        else begin
            failed++;
            $error("FAIL %s: got {he,gr,ack,sd,busy}=%b expected %b", x.tag, got, x.val);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.dbg_mode = 1'b0;
        bus.req      = 2'b00;
        bus.step_req = 2'b00;
        bus.step_len = 8'd0;
        cyc("reset", 0, 2'b00, 2'b00, 0, 0);
        rst_n = 1'b1;

        bus.dbg_mode = 1'b1;
        bus.req      = 2'b01;
        cyc("basic_drain0", 1, 2'b01, 2'b00, 0, 1);
        cyc("basic_drain1", 1, 2'b01, 2'b00, 0, 1);
        cyc("basic_ack",    1, 2'b01, 2'b01, 0, 1);
        cyc("basic_hold",   1, 2'b01, 2'b01, 0, 1);
        bus.req = 2'b00;
        cyc("basic_release", 0, 2'b00, 2'b00, 0, 0);

        bus.dbg_mode = 1'b0;
        bus.req      = 2'b01;
        cyc("nodbg_a", 0, 2'b00, 2'b00, 0, 0);
        cyc("nodbg_b", 0, 2'b00, 2'b00, 0, 0);

        bus.dbg_mode = 1'b1;
        cyc("wrap_grant0", 1, 2'b01, 2'b00, 0, 1);
        cyc("wrap_drain",  1, 2'b01, 2'b00, 0, 1);
        cyc("wrap_ack",    1, 2'b01, 2'b01, 0, 1);

        bus.step_req = 2'b01;
        bus.step_len = 8'd0;
        cyc("step_len0_ign", 1, 2'b01, 2'b01, 0, 1);
        bus.step_req = 2'b10;
        bus.step_len = 8'd3;
        cyc("step_nonowner_ign", 1, 2'b01, 2'b01, 0, 1);

        bus.step_req = 2'b01;
        cyc("step_enter", 0, 2'b01, 2'b00, 0, 1);
        bus.step_req = 2'b00;
        bus.step_len = 8'd0;
        cyc("step_run1",   0, 2'b01, 2'b00, 0, 1);
        cyc("step_run2",   0, 2'b01, 2'b00, 0, 1);
        cyc("step_rehalt", 1, 2'b01, 2'b00, 0, 1);
        cyc("step_drain",  1, 2'b01, 2'b00, 0, 1);
        cyc("step_done",   1, 2'b01, 2'b01, 1, 1);
        cyc("step_done_clr", 1, 2'b01, 2'b01, 0, 1);

        bus.step_req = 2'b01;
        bus.step_len = 8'd5;
        cyc("abort_step_enter", 0, 2'b01, 2'b00, 0, 1);
        bus.step_req = 2'b00;
        bus.dbg_mode = 1'b0;
        cyc("abort_step", 0, 2'b00, 2'b00, 0, 0);
        cyc("abort_step_idle", 0, 2'b00, 2'b00, 0, 0);

        bus.dbg_mode = 1'b1;
        cyc("abort_drain_enter", 1, 2'b01, 2'b00, 0, 1);
        bus.dbg_mode = 1'b0;
        cyc("abort_drain", 0, 2'b00, 2'b00, 0, 0);

        bus.dbg_mode = 1'b1;
        cyc("prio_drain0", 1, 2'b01, 2'b00, 0, 1);
        cyc("prio_drain1", 1, 2'b01, 2'b00, 0, 1);
        cyc("prio_ack",    1, 2'b01, 2'b01, 0, 1);
        bus.req      = 2'b00;
        bus.step_req = 2'b01;
        bus.step_len = 8'd4;
        cyc("release_over_step", 0, 2'b00, 2'b00, 0, 0);
        bus.step_req = 2'b00;

        bus.req = 2'b01;
        cyc("rst_drain0", 1, 2'b01, 2'b00, 0, 1);
        cyc("rst_drain1", 1, 2'b01, 2'b00, 0, 1);
        cyc("rst_ack",    1, 2'b01, 2'b01, 0, 1);
        rst_n = 1'b0;
        cyc("rst_mid", 0, 2'b00, 2'b00, 0, 0);
        rst_n = 1'b1;
        cyc("rst_regrant", 1, 2'b01, 2'b00, 0, 1);
        cyc("rst_drain",   1, 2'b01, 2'b00, 0, 1);
        cyc("rst_reack",   1, 2'b01, 2'b01, 0, 1);

        bus.req = 2'b11;
        cyc("rr_hold_owner", 1, 2'b01, 2'b01, 0, 1);
        bus.req = 2'b10;
        cyc("rr_release_idle", 0, 2'b00, 2'b00, 0, 0);
        bus.req = 2'b11;
        cyc("rr_grant1", 1, 2'b10, 2'b00, 0, 1);
        cyc("rr_drain",  1, 2'b10, 2'b00, 0, 1);
        cyc("rr_ack1",   1, 2'b10, 2'b10, 0, 1);
        bus.req = 2'b00;
        cyc("rr_release", 0, 2'b00, 2'b00, 0, 0);

        rst_n = 1'b0;
        cyc("rr_reset", 0, 2'b00, 2'b00, 0, 0);
        rst_n   = 1'b1;
        bus.req = 2'b11;
        cyc("rr_fresh_grant0", 1, 2'b01, 2'b00, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/halt_sched.md
Name: halt_sched

Overview:
- Debug-halt scheduler for the timer counter.
- Arbitrates up to NUM_REQ debug requesters (harts/debug modules) for ownership of the counter freeze.
- Drives the counter halt enable and waits a configurable drain period before acknowledging the owner.
- Supports owner-initiated single-step: the counter runs for a programmed number of cycles, then re-halts.

Parameters:
- NUM_REQ, 2: number of debug requesters, range 2..8.
- DRAIN_CYC, 2: cycles between halt_en assertion and halt_ack, range 1..15.
- STEP_W, 8: width of the step length field.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- dbg_mode  input  1  debug mode enable; low forbids and aborts any halt.
- req  input  NUM_REQ  per-requester halt request, level. The owner holds ownership while its bit stays high.
- step_req  input  NUM_REQ  per-requester single-cycle step pulse. Only the owner's bit is honoured, and only in HALTED.
- step_len  input  STEP_W  counter run length for a step, sampled when a step is accepted.
- halt_en  output  1  registered counter freeze enable.
- grant  output  NUM_REQ  registered one-hot owner, zero when there is no owner.
- halt_ack  output  NUM_REQ  registered; the owner's bit is high only in HALTED.
- step_done  output  1  one-cycle pulse when a step completes and the counter is re-halted.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: state IDLE; halt_en, grant, halt_ack, step_done all 0; RR pointer 0; drain counter 0; step counter 0; step flag 0.
- States: IDLE, DRAIN, HALTED, STEP.
- All outputs are registered and change only on the clk edge that enters the corresponding state.

Arbitration (IDLE):
- When dbg_mode=1 and req!=0: pick the first set req bit searching upward from the pointer, wrapping modulo NUM_REQ.
- Winner written to grant; pointer <= winner+1 mod NUM_REQ.
- halt_en <= 1; drain_cnt <= DRAIN_CYC-1; go to DRAIN.
- When dbg_mode=0, req is ignored.

DRAIN:
- If drain_cnt==0: go to HALTED, halt_ack <= grant. If the step flag is set, also pulse step_done=1 and clear the flag. Otherwise decrement drain_cnt.
- Latency: a req sampled high at edge N gives halt_en high from N+1 and halt_ack high from N+1+DRAIN_CYC.

HALTED:
- Owner's req drops: go to IDLE next edge; halt_en, grant and halt_ack all go to 0 together.
- Else owner's step_req=1 and step_len!=0: go to STEP; halt_en <= 0; halt_ack <= 0; step_cnt <= step_len-1; set the step flag.
- step_len==0 or a non-owner step_req: ignored, no state change.
- Release takes priority over step when both occur in the same cycle.

STEP:
- If step_cnt==0: go to DRAIN; halt_en <= 1; drain_cnt <= DRAIN_CYC-1. Otherwise decrement.
- halt_en is low for exactly step_len cycles.
- grant is held throughout STEP and DRAIN.

Abort conditions:
- From DRAIN, HALTED or STEP, any of the following sends the block to IDLE on the next edge: dbg_mode=0, or the owner's req dropping.
- On abort, all outputs clear and the step flag clears. No step_done is issued.
- Abort has the highest priority over all other transitions.

Other requesters:
- Non-owner req bits are ignored until the block returns to IDLE. They are then arbitrated no earlier than the cycle after the return, so there is at least one IDLE cycle with halt_en=0 between owners.

Reset mid-operation:
- rst_n low at any edge forces all reset values on that edge, regardless of state or inputs.

Counter widths:
- drain_cnt is 4 bits.
- step_cnt is STEP_W bits.
- No wrap: counters load and count down only to 0.

Test Plan:
- Basic halt: DRAIN_CYC=2, dbg_mode=1, req=01 at edge 0 -> grant=01 and halt_en=1 at edge 1; halt_ack=01 at edge 3; req drops -> halt_en, grant and halt_ack all 0 one edge later.
- Round-robin: req=11 held, owner 0 releases via a req[0] low pulse -> one IDLE cycle, then grant=10. A later simultaneous req=11 from reset gives grant=01 first.
- Single step: in HALTED, owner pulses step_req with step_len=3 -> halt_en low for exactly 3 cycles, then high; step_done pulses on the same edge halt_ack returns, DRAIN_CYC cycles after halt_en reasserts.
- Ignored steps: step_len=0, or step_req from the non-owner -> no change to halt_en or halt_ack, no step_done.
- Abort: dbg_mode dropped during DRAIN, and separately during STEP -> IDLE next edge, all outputs 0, no step_done. With dbg_mode=0 and req=01 held, grant stays 0.
- Reset: rst_n low in HALTED -> all outputs 0 on that edge; after release with req still high, the handshake restarts with grant=01 at the first post-reset edge.
